// File: rtl/traffic_light_mode_supervisor.sv
// rtl/traffic_light_mode_supervisor.sv - supervises startup, normal, flashing and all-red clearance modes of a traffic controller
module traffic_light_mode_supervisor #(
  parameter int STARTUP_CYCLES  = 30,
  parameter int CLEAR_CYCLES    = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flash_req,
  input  logic       fault,
  input  logic       fault_clr,
  input  logic [2:0] norm_pri_ryb,
  input  logic [2:0] norm_sec_ryb,
  input  logic [2:0] flash_pri_ryb,
  input  logic [2:0] flash_sec_ryb,
  output logic       normal_ssm_idle,
  output logic       flashing_mode_ssm_idle,
  output logic [2:0] pri_ryb,
  output logic [2:0] sec_ryb,
  output logic [2:0] mode,
  output logic       fault_latched
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [15:0] STARTUP_LOAD = 16'(STARTUP_CYCLES);
  localparam logic [15:0] CLEAR_LOAD   = 16'(CLEAR_CYCLES);
  localparam logic [15:0] DB_LAST      = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_STARTUP         = 3'd0,
    ST_NORMAL          = 3'd1,
    ST_CLEAR_TO_FLASH  = 3'd2,
    ST_FLASH           = 3'd3,
    ST_CLEAR_TO_NORMAL = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        timer_load;
  logic [15:0] state_timer;
  logic        timer_done;

  logic        sync_1;
  logic        sync_2;
  logic [15:0] db_cnt;
  logic        flash_req_db;

  logic        conflict;
  logic        want_flash;
  logic [2:0]  pri_d;
  logic [2:0]  sec_d;
  logic        normal_idle_d;
  logic        flash_idle_d;

  assign timer_done = (state_timer == 16'd0);
  assign want_flash = flash_req_db | fault_latched;
  assign mode       = state;

  // Two-flop synchronizer for the asynchronous operator switch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= flash_req;
      sync_2 <= sync_1;
    end
  end

  // Debounce: accept the new level only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt       <= 16'd0;
      flash_req_db <= 1'b0;
    end else if (sync_2 != flash_req_db) begin
      if (db_cnt == DB_LAST) begin
        flash_req_db <= sync_2;
        db_cnt       <= 16'd0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end else begin
      db_cnt <= 16'd0;
    end
  end

  // Dwell timer: loads on entry to a clearance, counts down and holds at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_timer <= STARTUP_LOAD;
    end else if (timer_load) begin
      state_timer <= CLEAR_LOAD;
    end else if (!timer_done) begin
      state_timer <= state_timer - 16'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_STARTUP;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decision and clearance timer loads.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    case (state)
      ST_STARTUP: begin
        if (timer_done) begin
          next_state = want_flash ? ST_FLASH : ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        if (want_flash) begin
          next_state = ST_CLEAR_TO_FLASH;
          timer_load = 1'b1;
        end
      end
      ST_CLEAR_TO_FLASH: begin
        if (timer_done) begin
          next_state = ST_FLASH;
        end
      end
      ST_FLASH: begin
        if (!want_flash) begin
          next_state = ST_CLEAR_TO_NORMAL;
          timer_load = 1'b1;
        end
      end
      ST_CLEAR_TO_NORMAL: begin
        if (timer_done) begin
          next_state = want_flash ? ST_FLASH : ST_NORMAL;
        end
      end
      default: begin
        next_state = ST_CLEAR_TO_FLASH;
        timer_load = 1'b1;
      end
    endcase
  end

  // Lamp source selection for the upcoming state; an illegal green pattern is never displayed.
  always_comb begin
    conflict      = 1'b0;
    pri_d         = RED;
    sec_d         = RED;
    normal_idle_d = 1'b1;
    flash_idle_d  = 1'b1;
    case (next_state)
      ST_NORMAL: begin
        normal_idle_d = 1'b0;
        if ((norm_pri_ryb == GREEN) && (norm_sec_ryb == GREEN)) begin
          conflict = 1'b1;
        end else begin
          pri_d = norm_pri_ryb;
          sec_d = norm_sec_ryb;
        end
      end
      ST_FLASH: begin
        flash_idle_d = 1'b0;
        if ((flash_pri_ryb == GREEN) || (flash_sec_ryb == GREEN)) begin
          conflict = 1'b1;
        end else begin
          pri_d = flash_pri_ryb;
          sec_d = flash_sec_ryb;
        end
      end
      default: begin
        pri_d = RED;
        sec_d = RED;
      end
    endcase
  end

  // Registered lamp, idle and sticky fault outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri_ryb                <= RED;
      sec_ryb                <= RED;
      normal_ssm_idle        <= 1'b1;
      flashing_mode_ssm_idle <= 1'b1;
      fault_latched          <= 1'b0;
    end else begin
      pri_ryb                <= pri_d;
      sec_ryb                <= sec_d;
      normal_ssm_idle        <= normal_idle_d;
      flashing_mode_ssm_idle <= flash_idle_d;
      if (fault || conflict) begin
        fault_latched <= 1'b1;
      end else if (fault_clr) begin
        fault_latched <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_mode_supervisor.sv
// tb/tb_traffic_light_mode_supervisor.sv - directed vector bench for traffic_light_mode_supervisor
module tb_traffic_light_mode_supervisor;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flash_req;
  logic       fault;
  logic       fault_clr;
  logic [2:0] norm_pri_ryb;
  logic [2:0] norm_sec_ryb;
  logic [2:0] flash_pri_ryb;
  logic [2:0] flash_sec_ryb;
  logic       normal_ssm_idle;
  logic       flashing_mode_ssm_idle;
  logic [2:0] pri_ryb;
  logic [2:0] sec_ryb;
  logic [2:0] mode;
  logic       fault_latched;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_mode_supervisor #(
    .STARTUP_CYCLES (5),
    .CLEAR_CYCLES   (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .flash_req             (flash_req),
    .fault                 (fault),
    .fault_clr             (fault_clr),
    .norm_pri_ryb          (norm_pri_ryb),
    .norm_sec_ryb          (norm_sec_ryb),
    .flash_pri_ryb         (flash_pri_ryb),
    .flash_sec_ryb         (flash_sec_ryb),
    .normal_ssm_idle       (normal_ssm_idle),
    .flashing_mode_ssm_idle(flashing_mode_ssm_idle),
    .pri_ryb               (pri_ryb),
    .sec_ryb               (sec_ryb),
    .mode                  (mode),
    .fault_latched         (fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] np;
    logic [2:0] ns;
    logic [2:0] ep;
    logic [2:0] es;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_mode(input string nm, input int m);
    chk({nm, " mode"}, int'(mode), m);
  endtask

  task automatic chk_all(input string nm, input int m, input int p, input int s,
                         input int ni, input int fi, input int fl);
    chk({nm, " mode"}, int'(mode), m);
    chk({nm, " pri"}, int'(pri_ryb), p);
    chk({nm, " sec"}, int'(sec_ryb), s);
    chk({nm, " norm_idle"}, int'(normal_ssm_idle), ni);
    chk({nm, " flash_idle"}, int'(flashing_mode_ssm_idle), fi);
    chk({nm, " fault_latched"}, int'(fault_latched), fl);
  endtask

  task automatic chk_run(input string nm, input int m, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_mode(nm, m);
    end
  endtask

  initial begin
    vecs[0] = '{YELLOW, RED,    YELLOW, RED};
    vecs[1] = '{RED,    GREEN,  RED,    GREEN};
    vecs[2] = '{RED,    YELLOW, RED,    YELLOW};
    vecs[3] = '{OFF,    OFF,    OFF,    OFF};
    vecs[4] = '{GREEN,  YELLOW, GREEN,  YELLOW};
    vecs[5] = '{RED,    RED,    RED,    RED};
    vecs[6] = '{GREEN,  RED,    GREEN,  RED};

    reset_n       = 1'b0;
    flash_req     = 1'b0;
    fault         = 1'b0;
    fault_clr     = 1'b0;
    norm_pri_ryb  = GREEN;
    norm_sec_ryb  = RED;
    flash_pri_ryb = YELLOW;
    flash_sec_ryb = RED;

    repeat (3) step();
    chk_all("reset", 0, RED, RED, 1, 1, 0);

    // Startup hold then normal
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("startup", 0, RED, RED, 1, 1, 0);
    end
    step();
    chk_all("enter_normal", 1, GREEN, RED, 0, 1, 0);

    // Normal lamp pass-through table
    for (int i = 0; i < 7; i++) begin
      norm_pri_ryb = vecs[i].np;
      norm_sec_ryb = vecs[i].ns;
      step();
      chk_all($sformatf("normal_vec%0d", i), 1, vecs[i].ep, vecs[i].es, 0, 1, 0);
    end

    // Two-cycle glitch must be rejected
    flash_req = 1'b1;
    step();
    step();
    flash_req = 1'b0;
    chk_run("glitch", 1, 10);

    // Held request: 5 cycles of sync+debounce, then clearance, then flash
    flash_req = 1'b1;
    chk_run("flash_latency", 1, 5);
    step();
    chk_all("enter_ctf", 2, RED, RED, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("ctf_hold", 2, RED, RED, 1, 1, 0);
    end
    step();
    chk_all("enter_flash", 3, YELLOW, RED, 1, 0, 0);

    // Release request: back through clear-to-normal
    flash_req = 1'b0;
    chk_run("unflash_latency", 3, 5);
    step();
    chk_all("enter_ctn", 4, RED, RED, 1, 1, 0);
    chk_run("ctn_hold", 4, 4);
    step();
    chk_all("back_normal", 1, GREEN, RED, 0, 1, 0);

    // Fault pulse forces flashing until acknowledged
    fault = 1'b1;
    step();
    fault = 1'b0;
    chk_all("fault_set", 1, GREEN, RED, 0, 1, 1);
    step();
    chk_all("fault_ctf", 2, RED, RED, 1, 1, 1);
    chk_run("fault_ctf_hold", 2, 4);
    step();
    chk_all("fault_flash", 3, YELLOW, RED, 1, 0, 1);
    chk_run("fault_flash_stay", 3, 3);
    fault     = 1'b1;
    fault_clr = 1'b1;
    step();
    chk("fault_over_clr", int'(fault_latched), 1);
    fault = 1'b0;
    step();
    fault_clr = 1'b0;
    chk_all("fault_cleared", 3, YELLOW, RED, 1, 0, 0);
    step();
    chk_all("fault_ctn", 4, RED, RED, 1, 1, 0);
    chk_run("fault_ctn_hold", 4, 4);
    step();
    chk_all("fault_normal", 1, GREEN, RED, 0, 1, 0);

    // Double green in normal: red immediately, fault latched, then clearance
    norm_pri_ryb = GREEN;
    norm_sec_ryb = GREEN;
    step();
    chk_all("conflict_red", 1, RED, RED, 0, 1, 1);
    norm_sec_ryb = RED;
    step();
    chk_all("conflict_ctf", 2, RED, RED, 1, 1, 1);
    step();
    chk_mode("conflict_ctf2", 2);

    // Asynchronous reset in the middle of clearance
    reset_n = 1'b0;
    #2;
    chk_all("async_reset", 0, RED, RED, 1, 1, 0);
    step();
    chk_all("async_reset_held", 0, RED, RED, 1, 1, 0);
    reset_n = 1'b1;
    chk_run("restart", 0, 5);
    step();
    chk_all("restart_normal", 1, GREEN, RED, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
